// File: rtl/eth_fifo_pkg.sv
// Shared sizing constants for the Ethernet payload FIFO and the frame packer.
package eth_fifo_pkg;

    localparam int DATA_WIDTH_DEF    = 8;
    localparam int ADDR_WIDTH_DEF    = 10;

    // Number of storage words for a given pointer width.
    function automatic int depth_of(input int addr_width);
        return 32'sd1 << addr_width;
    endfunction

    localparam int DEPTH             = depth_of(ADDR_WIDTH_DEF);
    localparam int COUNT_WIDTH       = ADDR_WIDTH_DEF + 1;

    // Payload bytes the packer drains per frame once this many are buffered.
    localparam int FRAME_PAYLOAD_LEN = 512;

endpackage

// File: rtl/eth_payload_fifo_if.sv
// AXI-Stream byte lane: master drives data/valid, slave drives ready.
interface eth_payload_fifo_if #(
    parameter int DATA_WIDTH = 8
);
    logic [DATA_WIDTH-1:0] tdata;
    logic                  tvalid;
    logic                  tready;

    modport master (output tdata, output tvalid, input tready);
    modport slave  (input tdata, input tvalid, output tready);
endinterface

// File: rtl/eth_fifo_ram.sv
// Simple dual-port RAM with a registered read port; maps onto block RAM.
module eth_fifo_ram #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 10
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  we_i,
    input  logic [ADDR_WIDTH-1:0] waddr_i,
    input  logic [DATA_WIDTH-1:0] wdata_i,
    input  logic                  re_i,
    input  logic [ADDR_WIDTH-1:0] raddr_i,
    output logic [DATA_WIDTH-1:0] rdata_o
);
    localparam int DEPTH = 1 << ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [DATA_WIDTH-1:0] rdata_q;

    // Write port: storage array has no reset so it stays a plain RAM.
    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    // Read port: output register holds its word until the next read enable.
    always_ff @(posedge clk) begin
        if (rst) begin
            rdata_q <= {DATA_WIDTH{1'b0}};
        end else if (re_i) begin
            rdata_q <= mem_q[raddr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/eth_payload_fifo.sv
// Byte FIFO feeding the frame packer: RAM plus a two-slot FWFT output pipeline
// (RAM read register and skid register) with exact occupancy counters.
module eth_payload_fifo
    import eth_fifo_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int ADDR_WIDTH = ADDR_WIDTH_DEF
) (
    input  logic                clk,
    input  logic                rst,
    eth_payload_fifo_if.slave   s_axis,
    eth_payload_fifo_if.master  m_axis,
    output logic [ADDR_WIDTH:0] wr_data_count,
    output logic [ADDR_WIDTH:0] rd_data_count
);
    localparam int             CW     = ADDR_WIDTH + 1;
    localparam logic [CW-1:0]  FULL_C = CW'(depth_of(ADDR_WIDTH));
    localparam logic [CW-1:0]  ONE_C  = CW'(1'b1);

    logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]         wr_cnt_q, wr_cnt_d;
    logic [CW-1:0]         rd_cnt_q, rd_cnt_d;
    logic [CW-1:0]         ram_cnt_q, ram_cnt_d;
    logic                  wr_stb_q;
    logic                  s_rdy_q, s_rdy_d;
    logic                  v0_q, v0_d;      // RAM read register holds a word
    logic                  v1_q, v1_d;      // skid register holds the older word
    logic [DATA_WIDTH-1:0] skid_q, skid_d;

    logic [DATA_WIDTH-1:0] ram_rdata_s;
    logic                  s_rdy_s;
    logic                  push_s;
    logic                  pop_s;
    logic                  keep_skid_s;
    logic                  keep_rd_s;
    logic                  re_s;

    // Ready is gated low while reset is held so nothing is accepted then.
    assign s_rdy_s        = s_rdy_q & ~rst;
    assign s_axis.tready  = s_rdy_s;
    assign m_axis.tvalid  = v0_q | v1_q;
    assign m_axis.tdata   = v1_q ? skid_q : ram_rdata_s;
    assign wr_data_count  = wr_cnt_q;
    assign rd_data_count  = rd_cnt_q;

    // Handshakes, surviving pipeline words and the prefetch decision.
    always_comb begin
        push_s      = s_axis.tvalid & s_rdy_s;
        pop_s       = (v0_q | v1_q) & m_axis.tready;
        // A pop always consumes the skid word first when it is present.
        keep_skid_s = v1_q & ~pop_s;
        keep_rd_s   = v0_q & (v1_q | ~pop_s);
        re_s        = (ram_cnt_q != {CW{1'b0}}) & ~(keep_skid_s & keep_rd_s);
    end

    // Output pipeline next state: a prefetched word always lands in the RAM
    // read register, so any surviving word is parked in the skid register.
    always_comb begin
        v0_d   = v0_q;
        v1_d   = v1_q;
        skid_d = skid_q;
        if (re_s) begin
            v0_d   = 1'b1;
            v1_d   = keep_skid_s | keep_rd_s;
            skid_d = keep_rd_s ? ram_rdata_s : skid_q;
        end else begin
            v0_d   = keep_rd_s;
            v1_d   = keep_skid_s;
            skid_d = skid_q;
        end
    end

    // Pointer advance on RAM write and prefetch.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (push_s) begin
            wr_ptr_d = wr_ptr_q + {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        if (re_s) begin
            rd_ptr_d = rd_ptr_q + {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
    end

    // Occupancy counters; read view lags writes by one cycle via wr_stb_q.
    always_comb begin
        wr_cnt_d  = wr_cnt_q;
        rd_cnt_d  = rd_cnt_q;
        ram_cnt_d = ram_cnt_q;
        case ({push_s, pop_s})
            2'b10:   wr_cnt_d = wr_cnt_q + ONE_C;
            2'b01:   wr_cnt_d = wr_cnt_q - ONE_C;
            default: wr_cnt_d = wr_cnt_q;
        endcase
        case ({wr_stb_q, pop_s})
            2'b10:   rd_cnt_d = rd_cnt_q + ONE_C;
            2'b01:   rd_cnt_d = rd_cnt_q - ONE_C;
            default: rd_cnt_d = rd_cnt_q;
        endcase
        case ({push_s, re_s})
            2'b10:   ram_cnt_d = ram_cnt_q + ONE_C;
            2'b01:   ram_cnt_d = ram_cnt_q - ONE_C;
            default: ram_cnt_d = ram_cnt_q;
        endcase
        s_rdy_d = (wr_cnt_d != FULL_C);
    end

    // State registers with synchronous reset; reset drops all buffered words.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q  <= {ADDR_WIDTH{1'b0}};
            rd_ptr_q  <= {ADDR_WIDTH{1'b0}};
            wr_cnt_q  <= {CW{1'b0}};
            rd_cnt_q  <= {CW{1'b0}};
            ram_cnt_q <= {CW{1'b0}};
            wr_stb_q  <= 1'b0;
            s_rdy_q   <= 1'b1;
            v0_q      <= 1'b0;
            v1_q      <= 1'b0;
            skid_q    <= {DATA_WIDTH{1'b0}};
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            wr_cnt_q  <= wr_cnt_d;
            rd_cnt_q  <= rd_cnt_d;
            ram_cnt_q <= ram_cnt_d;
            wr_stb_q  <= push_s;
            s_rdy_q   <= s_rdy_d;
            v0_q      <= v0_d;
            v1_q      <= v1_d;
            skid_q    <= skid_d;
        end
    end

    eth_fifo_ram #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_ram (
        .clk     (clk),
        .rst     (rst),
        .we_i    (push_s),
        .waddr_i (wr_ptr_q),
        .wdata_i (s_axis.tdata),
        .re_i    (re_s),
        .raddr_i (rd_ptr_q),
        .rdata_o (ram_rdata_s)
    );

endmodule

// File: tb/tb_eth_payload_fifo.sv
// Self-checking bench for eth_payload_fifo: directed cases plus random traffic
// against a queue-based reference model.
module tb_eth_payload_fifo;

    logic        clk;
    logic        rst;
    logic [10:0] wr_data_count;
    logic [10:0] rd_data_count;

    eth_payload_fifo_if #(.DATA_WIDTH(8)) s_if ();
    eth_payload_fifo_if #(.DATA_WIDTH(8)) m_if ();

    eth_payload_fifo dut (
        .clk           (clk),
        .rst           (rst),
        .s_axis        (s_if),
        .m_axis        (m_if),
        .wr_data_count (wr_data_count),
        .rd_data_count (rd_data_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_total = 0;
    int n_bad   = 0;

    // Single comparison point: counts every check and reports mismatches.
    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference model: queue of accepted bytes not yet read out.
    logic [7:0] ref_q [$];
    int         last_push = 0;
    bit         chk_en    = 1'b0;
    int         exp_rd;
    bit         mon_push;
    bit         mon_pop;

    // Per-cycle check of counts, ready, valid and head data, then model update.
    always @(negedge clk) begin
        if (chk_en) begin
            exp_rd = ref_q.size() - last_push;
            chk("wr_cnt", wr_data_count, ref_q.size());
            chk("rd_cnt", rd_data_count, exp_rd);
            if (rst) chk("rdy_in_rst", s_if.tready, 0);
            else     chk("rdy", s_if.tready, (ref_q.size() != 1024));
            chk("vld", m_if.tvalid, (exp_rd != 0));
            if (m_if.tvalid && ref_q.size() > 0) chk("data", m_if.tdata, ref_q[0]);
            if (rst) begin
                ref_q.delete();
                last_push = 0;
            end else begin
                mon_push = s_if.tvalid && s_if.tready;
                mon_pop  = m_if.tvalid && m_if.tready;
                if (mon_pop) begin
                    if (ref_q.size() == 0) chk("pop_empty", 1, 0);
                    else void'(ref_q.pop_front());
                end
                if (mon_push) ref_q.push_back(s_if.tdata);
                last_push = mon_push ? 1 : 0;
            end
        end
    end

    // Offer one byte and wait (bounded) until it is accepted.
    task automatic push_byte(input logic [7:0] d);
        bit done;
        done = 1'b0;
        s_if.tvalid = 1'b1;
        s_if.tdata  = d;
        for (int c = 0; c < 2000 && !done; c++) begin
            if (s_if.tready) done = 1'b1;
            tick();
        end
        s_if.tvalid = 1'b0;
        if (!done) chk("push_timeout", 0, 1);
    endtask

    task automatic wait_wr(input int target, input int budget, input string tag);
        int c;
        c = 0;
        while (wr_data_count != target && c < budget) begin
            tick();
            c++;
        end
        chk(tag, wr_data_count, target);
    endtask

    task automatic drain(input string tag);
        m_if.tready = 1'b1;
        wait_wr(0, 3000, tag);
        tick();
        m_if.tready = 1'b0;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int   sent;
        int   cyc;
        bit   acc;
        logic [7:0] seq;

        rst = 1'b1;
        s_if.tvalid = 1'b0;
        s_if.tdata  = 8'h00;
        m_if.tready = 1'b0;
        tick();
        tick();
        @(negedge clk);
        chk("rst_rdy0", s_if.tready, 0);
        chk("rst_vld", m_if.tvalid, 0);
        chk("rst_data", m_if.tdata, 0);
        chk("rst_wr", wr_data_count, 0);
        chk("rst_rd", rd_data_count, 0);
        tick();
        rst = 1'b0;
        tick();
        chk_en = 1'b1;
        @(negedge clk);
        chk("rst_rdy1", s_if.tready, 1);

        // Single byte latency and hold.
        tick();
        s_if.tvalid = 1'b1;
        s_if.tdata  = 8'hA5;
        tick();
        s_if.tvalid = 1'b0;
        @(negedge clk);
        chk("one_wr1", wr_data_count, 1);
        chk("one_rd1", rd_data_count, 0);
        chk("one_vld1", m_if.tvalid, 0);
        tick();
        @(negedge clk);
        chk("one_rd2", rd_data_count, 1);
        chk("one_vld2", m_if.tvalid, 1);
        chk("one_data2", m_if.tdata, 8'hA5);
        tick();
        @(negedge clk);
        chk("one_hold", m_if.tdata, 8'hA5);
        m_if.tready = 1'b1;
        tick();
        m_if.tready = 1'b0;
        @(negedge clk);
        chk("one_wr_end", wr_data_count, 0);
        chk("one_rd_end", rd_data_count, 0);
        chk("one_vld_end", m_if.tvalid, 0);

        // Fill to capacity, hold an extra beat, free one slot.
        for (int i = 0; i < 1024; i++) push_byte(8'(i));
        @(negedge clk);
        chk("full_wr", wr_data_count, 1024);
        chk("full_rdy", s_if.tready, 0);
        s_if.tvalid = 1'b1;
        s_if.tdata  = 8'h77;
        repeat (3) tick();
        @(negedge clk);
        chk("full_hold", wr_data_count, 1024);
        m_if.tready = 1'b1;
        tick();
        m_if.tready = 1'b0;
        @(negedge clk);
        chk("full_rd1_wr", wr_data_count, 1023);
        chk("full_rd1_rdy", s_if.tready, 1);
        tick();
        s_if.tvalid = 1'b0;
        @(negedge clk);
        chk("full_refill", wr_data_count, 1024);
        drain("full_drain");

        // Frame burst: 512 beats on consecutive cycles.
        for (int i = 0; i < 512; i++) push_byte(8'(i));
        chk("frm_wr", wr_data_count, 512);
        m_if.tready = 1'b1;
        for (int b = 0; b < 512; b++) begin
            @(negedge clk);
            chk("frm_beat", m_if.tvalid, 1);
            tick();
        end
        m_if.tready = 1'b0;
        @(negedge clk);
        chk("frm_wr_end", wr_data_count, 0);
        chk("frm_rd_end", rd_data_count, 0);

        // Steady state: 100 words buffered, write and read every cycle.
        for (int i = 0; i < 100; i++) push_byte(8'(i + 7));
        tick();
        tick();
        seq = 8'h40;
        s_if.tvalid = 1'b1;
        m_if.tready = 1'b1;
        for (int c = 0; c < 5000; c++) begin
            s_if.tdata = seq;
            @(negedge clk);
            chk("steady_wr", wr_data_count, 100);
            tick();
            seq = seq + 8'd1;
        end
        s_if.tvalid = 1'b0;
        drain("steady_drain");

        // Random valid/ready traffic.
        sent = 0;
        cyc  = 0;
        while ((sent < 20000 || wr_data_count != 0) && cyc < 60000) begin
            if (sent < 20000 && !s_if.tvalid && ($urandom % 4) != 0) begin
                s_if.tvalid = 1'b1;
                s_if.tdata  = 8'($urandom);
            end
            m_if.tready = (($urandom % 4) != 0);
            acc = s_if.tvalid && s_if.tready;
            tick();
            cyc++;
            if (acc) begin
                sent++;
                s_if.tvalid = 1'b0;
            end
        end
        s_if.tvalid = 1'b0;
        m_if.tready = 1'b0;
        chk("rand_sent", sent, 20000);
        chk("rand_empty", wr_data_count, 0);

        // Reset with 300 words buffered.
        for (int i = 0; i < 300; i++) push_byte(8'(i * 3));
        tick();
        tick();
        chk("mid_wr", wr_data_count, 300);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        @(negedge clk);
        chk("mid_wr0", wr_data_count, 0);
        chk("mid_rd0", rd_data_count, 0);
        chk("mid_vld0", m_if.tvalid, 0);
        chk("mid_rdy1", s_if.tready, 1);
        tick();
        s_if.tvalid = 1'b1;
        s_if.tdata  = 8'h3C;
        tick();
        s_if.tvalid = 1'b0;
        tick();
        @(negedge clk);
        chk("mid_vld", m_if.tvalid, 1);
        chk("mid_first", m_if.tdata, 8'h3C);
        drain("mid_drain");

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
